// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: enqueue side, dequeue side, flush and status.
// The master drives enqueue payload, dequeue ready and flush; the slave is the queue.
interface fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int EXCW  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             flush_i;
   logic             enq_valid_i;
   logic             enq_ready_o;
   logic [XLEN-1:0]  enq_pc_i;
   logic [XLEN-1:0]  enq_pc_incr_i;
   logic [XLEN-1:0]  enq_inst_i;
   logic             enq_taken_i;
   logic [XLEN-1:0]  enq_target_i;
   logic [EXCW-1:0]  enq_exc_i;
   logic             deq_valid_o;
   logic             deq_ready_i;
   logic [XLEN-1:0]  deq_pc_o;
   logic [XLEN-1:0]  deq_pc_incr_o;
   logic [XLEN-1:0]  deq_inst_o;
   logic             deq_taken_o;
   logic [XLEN-1:0]  deq_target_o;
   logic [EXCW-1:0]  deq_exc_o;
   logic [CNT_W-1:0] count_o;
   logic             fenced_o;

   modport master (
      output flush_i, enq_valid_i, enq_pc_i, enq_pc_incr_i, enq_inst_i,
             enq_taken_i, enq_target_i, enq_exc_i, deq_ready_i,
      input  enq_ready_o, deq_valid_o, deq_pc_o, deq_pc_incr_o, deq_inst_o,
             deq_taken_o, deq_target_o, deq_exc_o, count_o, fenced_o
   );

   modport slave (
      input  flush_i, enq_valid_i, enq_pc_i, enq_pc_incr_i, enq_inst_i,
             enq_taken_i, enq_target_i, enq_exc_i, deq_ready_i,
      output enq_ready_o, deq_valid_o, deq_pc_o, deq_pc_incr_o, deq_inst_o,
             deq_taken_o, deq_target_o, deq_exc_o, count_o, fenced_o
   );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry ready/valid instruction fetch queue with flush squash and exception fence.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue enqueue passes straight through to deq_* in the same cycle.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int EXCW  = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   fetch_queue_if.slave fq
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_incr;
      logic [XLEN-1:0] inst;
      logic            taken;
      logic [XLEN-1:0] target;
      logic [EXCW-1:0] exc;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fenced_q, fenced_d;

   entry_t enq_entry;
   entry_t head;
   entry_t deq_entry;
   logic   full, empty;
   logic   enq_ready, deq_valid;
   logic   enq_fire, deq_fire;
   logic   bypass;
   logic   wr_en, rd_en;

   always_comb begin
      enq_entry = '{pc:      fq.enq_pc_i,
                    pc_incr: fq.enq_pc_incr_i,
                    inst:    fq.enq_inst_i,
                    taken:   fq.enq_taken_i,
                    target:  fq.enq_target_i,
                    exc:     fq.enq_exc_i};
      full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      empty = (wr_ptr_q == rd_ptr_q);
      // Ready never looks at enq_valid_i; full blocks even if decode drains this cycle.
      enq_ready = !full && !fenced_q && !rst_i && !fq.flush_i;
      head      = mem_q[rd_ptr_q[PTR_W-1:0]];
      bypass    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass    = empty && fq.enq_valid_i && enq_ready;
`endif
      deq_valid = bypass || !empty;
      deq_entry = bypass ? enq_entry : head;
      enq_fire  = fq.enq_valid_i && enq_ready;
      deq_fire  = deq_valid && fq.deq_ready_i && !fq.flush_i && !rst_i;
      // A bypassed entry consumed this cycle never touches storage.
      wr_en     = enq_fire && !(bypass && fq.deq_ready_i);
      rd_en     = deq_fire && !bypass;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      fenced_d = fenced_q;
      if (rst_i || fq.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         fenced_d = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
         if (enq_fire && (fq.enq_exc_i != '0)) fenced_d = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      if (wr_en) mem_d[wr_ptr_q[PTR_W-1:0]] = enq_entry;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fenced_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fenced_q <= fenced_d;
      end
   end

   // Payload storage carries no reset; validity comes from the pointers.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
   end

   assign fq.enq_ready_o   = enq_ready;
   assign fq.deq_valid_o   = deq_valid;
   assign fq.deq_pc_o      = deq_entry.pc;
   assign fq.deq_pc_incr_o = deq_entry.pc_incr;
   assign fq.deq_inst_o    = deq_entry.inst;
   assign fq.deq_taken_o   = deq_entry.taken;
   assign fq.deq_target_o  = deq_entry.target;
   assign fq.deq_exc_o     = deq_entry.exc;
   assign fq.count_o       = count_q;
   assign fq.fenced_o      = fenced_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-based reference model predicts
// acceptance and ordering; a negedge monitor pops and compares every dequeue handshake.
module tb_fetch_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int EXCW  = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_incr;
      logic [31:0] inst;
      logic        taken;
      logic [31:0] target;
      logic [3:0]  exc;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .EXCW(EXCW)) bus ();
   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EXCW(EXCW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .fq    (bus)
   );

   ent_t exp_q[$];
   bit   m_fenced   = 1'b0;
   bit   pred_ready = 1'b0;
   bit   last_acc   = 1'b0;
   bit   mon_en     = 1'b0;
   int   n_cmp      = 0;
   int   n_err      = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO order, capacity DEPTH, fence on any nonzero exception, flush/reset clears.
   task automatic model_update();
      last_acc = 1'b0;
      if (rst || bus.flush_i) begin
         exp_q.delete();
         m_fenced = 1'b0;
      end else if (bus.enq_valid_i && pred_ready) begin
         exp_q.push_back('{pc: bus.enq_pc_i, pc_incr: bus.enq_pc_incr_i, inst: bus.enq_inst_i,
                           taken: bus.enq_taken_i, target: bus.enq_target_i, exc: bus.enq_exc_i});
         if (bus.enq_exc_i != 4'd0) m_fenced = 1'b1;
         last_acc = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_enq(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                          input bit tk, input logic [31:0] tgt, input logic [3:0] exc);
      bus.enq_valid_i   = v;
      bus.enq_pc_i      = pc;
      bus.enq_pc_incr_i = pc + ((inst[1:0] == 2'b11) ? 32'd4 : 32'd2);
      bus.enq_inst_i    = inst;
      bus.enq_taken_i   = tk;
      bus.enq_target_i  = tgt;
      bus.enq_exc_i     = exc;
   endtask

   // Monitor: checks status against the model and pops whenever the DUT presents a dequeue.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            pred_ready = (exp_q.size() < DEPTH) && !m_fenced && !rst && !bus.flush_i;
            chk("count", 64'(bus.count_o), 64'(exp_q.size()));
            chk("deq_valid", 64'(bus.deq_valid_o), 64'(exp_q.size() != 0));
            chk("enq_ready", 64'(bus.enq_ready_o), 64'(pred_ready));
            chk("fenced", 64'(bus.fenced_o), 64'(m_fenced));
            if (bus.deq_valid_o && bus.deq_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL deq_unexpected: got pc %0h expected no entry", bus.deq_pc_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("deq_pc", 64'(bus.deq_pc_o), 64'(e.pc));
                  chk("deq_pc_incr", 64'(bus.deq_pc_incr_o), 64'(e.pc_incr));
                  chk("deq_inst", 64'(bus.deq_inst_o), 64'(e.inst));
                  chk("deq_taken", 64'(bus.deq_taken_o), 64'(e.taken));
                  chk("deq_target", 64'(bus.deq_target_o), 64'(e.target));
                  chk("deq_exc", 64'(bus.deq_exc_o), 64'(e.exc));
               end
            end
         end
      end
   end

   initial begin
      int t;
      logic [31:0] r;
      rst = 1'b1;
      bus.flush_i = 1'b0;
      bus.deq_ready_i = 1'b0;
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      step();
      mon_en = 1'b1;
      repeat (2) step();
      rst = 1'b0;

      // Single entry: visible one cycle after enqueue.
      set_enq(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 32'h0, 4'd0);
      step();
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      step();
      bus.deq_ready_i = 1'b1;
      step();
      bus.deq_ready_i = 1'b0;

      // Fill to DEPTH, hold a 5th entry until a dequeue frees a slot.
      for (int k = 1; k <= 4; k++) begin
         set_enq(1'b1, 32'h1000 + 32'(k * 4), 32'h0010_0093 + 32'(k << 20), k[0], 32'h2000 + 32'(k), 4'd0);
         step();
      end
      set_enq(1'b1, 32'h1014, 32'h0050_0093, 1'b1, 32'h3000, 4'd0);
      step();
      step();
      bus.deq_ready_i = 1'b1;
      step();
      bus.deq_ready_i = 1'b0;
      t = 0;
      while (!last_acc && t < 10) begin
         step();
         t++;
      end
      n_cmp++;
      if (!last_acc) begin
         n_err++;
         $display("FAIL fifth_accept: got not accepted expected accepted within 10 cycles");
      end
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      bus.deq_ready_i = 1'b1;
      repeat (6) step();

      // Streaming: pointers wrap twice with occupancy steady.
      for (int k = 0; k < 10; k++) begin
         set_enq(1'b1, 32'h8000_0000 + 32'(4 * k), 32'h0000_0013 + 32'(k << 7), 1'b0, 32'h0, 4'd0);
         step();
      end
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      repeat (2) step();

      // Exception fence: blocks younger fetches until flush.
      bus.deq_ready_i = 1'b0;
      set_enq(1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'd2);
      step();
      set_enq(1'b1, 32'h9000_0004, 32'h0000_0013, 1'b0, 32'h0, 4'd0);
      repeat (2) step();
      bus.deq_ready_i = 1'b1;
      repeat (2) step();
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      step();

      // Flush beats simultaneous enqueue and dequeue.
      bus.deq_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_enq(1'b1, 32'hA000_0000 + 32'(4 * k), 32'h0000_0013, 1'b0, 32'h0, 4'd0);
         step();
      end
      bus.flush_i = 1'b1;
      bus.deq_ready_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      step();

      // Reset with two entries queued and fenced.
      bus.deq_ready_i = 1'b0;
      set_enq(1'b1, 32'hB000_0000, 32'h0000_0013, 1'b0, 32'h0, 4'd0);
      step();
      set_enq(1'b1, 32'hB000_0004, 32'h0000_0013, 1'b0, 32'h0, 4'd5);
      step();
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Randomized traffic with occasional exceptions, flushes and resets.
      for (int c = 0; c < 3000; c++) begin
         r = $urandom;
         set_enq($urandom_range(0, 9) < 7, $urandom, $urandom, r[0], $urandom,
                 ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
         bus.deq_ready_i = ($urandom_range(0, 9) < 6);
         bus.flush_i     = ($urandom_range(0, 49) == 0);
         rst             = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      bus.flush_i = 1'b0;
      set_enq(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
